program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data word width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h01000000, address of the first loaded word.
REQ-004 SHALL have parameter MAX_WORDS, default 1024, largest legal image length in words.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port start_i, input, 1, request to begin a load.
REQ-008 SHALL have port len_words_i, input, 16, image length in words, sampled with start_i.
REQ-009 SHALL have port byte_valid_i, input, 1, source presents a byte.
REQ-010 SHALL have port byte_data_i, input, 8, image byte, little-endian order.
REQ-011 SHALL have port byte_ready_o, output, 1, loader accepts a byte this cycle.
REQ-012 SHALL have port mem_addr_o, output, AWIDTH, memory write address.
REQ-013 SHALL have port mem_data_o, output, DWIDTH, assembled word.
REQ-014 SHALL have port mem_write_en_o, output, 1, memory write strobe.
REQ-015 SHALL have port mem_read_en_o, output, 1, tied to 0.
REQ-016 SHALL have port mem_funct3_o, output, 3, tied to 3'b010 (word access).
REQ-017 SHALL have port core_rst_o, output, 1, holds the core in reset while loading.
REQ-018 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-019 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-020 SHALL have port error_o, output, 1, one-cycle pulse on an illegal length.

Function
REQ-021 SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-022 In IDLE with start_i=1 and 1<=len_words_i<=MAX_WORDS, SHALL latch the length, clear the word and byte counters, and go to COLLECT.
REQ-023 In IDLE with start_i=1 and len_words_i equal to 0 or greater than MAX_WORDS, SHALL pulse error_o the next cycle and stay in IDLE.
REQ-024 SHALL assert byte_ready_o only in COLLECT; a byte is transferred only when byte_valid_i and byte_ready_o are both 1.
REQ-025 SHALL place the transferred byte at bits [8*byte_cnt+7 : 8*byte_cnt] of the word register, with byte_cnt counting 0 to 3 and wrapping to 0.
REQ-026 On the transfer of the byte with byte_cnt=3, SHALL go to WRITE.
REQ-027 In WRITE, SHALL drive mem_write_en_o=1 for exactly one cycle, with mem_addr_o = BASE_ADDR + 4*word_cnt and mem_data_o = the assembled word.
REQ-028 In WRITE, SHALL go to DONE when word_cnt equals len-1, otherwise increment word_cnt and return to COLLECT.
REQ-029 In DONE, SHALL assert done_o for one cycle and then return to IDLE.
REQ-030 SHALL ignore start_i in every state other than IDLE.
REQ-031 SHALL hold mem_write_en_o at 0 outside WRITE, and SHALL hold mem_addr_o and mem_data_o stable whenever mem_write_en_o is 0.
REQ-032 SHALL drive core_rst_o = rst OR busy_o, which makes core_rst_o combinational.
REQ-033 SHALL have a throughput of at most one word per 5 cycles: 4 COLLECT transfers followed by 1 WRITE.

Reset
REQ-034 While rst=1, SHALL force the state to IDLE and clear both counters, the word register, done_o, error_o and mem_write_en_o; byte_ready_o and busy_o SHALL be 0.
REQ-035 A reset asserted mid-load SHALL abandon the load, with no further memory writes and no done_o pulse.

Structure
REQ-036 The package loader_pkg SHALL hold the state enum, the FUNCT3_WORD=3'b010 constant and the default BASE_ADDR.
REQ-037 Byte packing SHALL be implemented inline, with no sub-module.

Verification
REQ-038 The bench SHALL cover: start, len=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 at 0x01000000 and 0x00100093 at 0x01000004, done_o pulses once, busy_o then falls.
REQ-039 The bench SHALL cover: start with len=0, and start with len=1025 -> error_o pulses, no write, busy_o stays 0.
REQ-040 The bench SHALL cover: len=1 with byte_valid_i toggled every other cycle, bytes 73 00 00 00 -> a single write of 0x00000073, and no byte is accepted during WRITE.
REQ-041 The bench SHALL cover: rst asserted after 6 bytes of a len=3 load -> one write only, then IDLE, with no done_o.
REQ-042 The bench SHALL cover: start_i pulsed while busy -> ignored; the ongoing load completes with the original length.
REQ-043 The bench SHALL cover: core_rst_o is 1 from the cycle after start until done_o, and 0 afterwards.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, the word
// access funct3 code and the default load base address.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0]  FUNCT3_WORD       = 3'b010;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/program_loader.sv
// Streams a little-endian byte image into consecutive memory words starting
// at BASE_ADDR, holding the core in reset until the whole image is written.
module program_loader
  import loader_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       len_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_write_en_o,
  output logic              mem_read_en_o,
  output logic [2:0]        mem_funct3_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output state_t            state_o
);

  // Byte handshake: a byte moves on a rising edge exactly when byte_valid_i
  // and byte_ready_o are both 1 in the preceding cycle; the source must hold
  // byte_data_i stable while byte_valid_i is high and ready is low.

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;

  logic len_legal;
  logic load_ok;
  logic load_bad;
  logic accept;
  logic last_word;

  assign len_legal = (len_words_i != 16'd0) && ({1'b0, len_words_i} <= MAX_LEN);

  always_comb begin
    state_d   = state_q;
    load_ok   = 1'b0;
    load_bad  = 1'b0;
    accept    = 1'b0;
    last_word = (word_cnt_q == (len_q - 16'd1));
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_legal) begin
            load_ok = 1'b1;
            state_d = COLLECT;
          end else begin
            load_bad = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (byte_valid_i) begin
          accept = 1'b1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE:   state_d = last_word ? DONE : COLLECT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      word_cnt_q     <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      mem_write_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
    end else begin
      state_q        <= state_d;
      error_o        <= load_bad;
      done_o         <= (state_d == DONE);
      mem_write_en_o <= (state_d == WRITE);
      if (load_ok) begin
        len_q      <= len_words_i;
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
      end
      if (accept) begin
        word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
        byte_cnt_q                        <= byte_cnt_q + 2'd1;
        // Output registers only move when a word completes, so they stay
        // stable while the next word is being collected.
        if (byte_cnt_q == 2'd3) begin
          mem_addr_o <= BASE_ADDR + AWIDTH'({word_cnt_q, 2'b00});
          mem_data_o <= DWIDTH'({byte_data_i, word_q[23:0]});
        end
      end
      if ((state_q == WRITE) && !last_word) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign busy_o        = (state_q != IDLE) && !rst;
  assign byte_ready_o  = (state_q == COLLECT) && !rst;
  assign core_rst_o    = rst | busy_o;
  assign mem_read_en_o = 1'b0;
  assign mem_funct3_o  = FUNCT3_WORD;
  assign state_o       = state_q;

endmodule
